uart_digest_loader: RTL and testbench

Receives the target MD5 digest from the host over the board UART (8N1) and presents it as a 128-bit word to the generator. It sits between the host-side UART pin and the generator. It deserialises bytes with a mid-bit sampler, assembles 16 good bytes into a digest, and publishes the digest atomically with a one-cycle strobe. Framing errors and inter-byte timeouts discard the partial digest, so a half-sent digest never reaches the generator.

---
 rtl/uart_digest_loader.sv | 195 +++++++++++++++++++
 tb/tb_uart_digest_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_digest_loader.sv
// rtl/uart_digest_loader.sv - UART 8N1 receiver that assembles a 128-bit MD5 digest
//
// Receives 16 bytes from the host over an 8N1 serial line, assembles them into a
// 128-bit digest and publishes it atomically with a one-cycle strobe. A bad stop
// bit or an inter-byte idle timeout discards the partial digest.
//
// Ports:
//   clock         system clock, all logic on the rising edge
//   reset         asynchronous active-high reset
//   rxd           serial line from the host, idles high
//   digest        last complete digest, first byte in [127:120], 16th in [7:0]
//   digest_valid  one-cycle pulse when digest updates
//   loading       high while a frame is in progress or a partial digest is held
//   framing_error one-cycle pulse on a bad stop bit
module uart_digest_loader #(
    parameter int clock_freq   = 16000000,
    parameter int baud         = 115200,
    parameter int timeout_bits = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rxd,
    output logic [127:0] digest,
    output logic         digest_valid,
    output logic         loading,
    output logic         framing_error
);

    localparam int bit_period     = clock_freq / baud;
    localparam int half_period    = bit_period / 2;
    localparam int timeout_cycles = timeout_bits * bit_period;
    localparam int cnt_w          = $clog2(bit_period + 1);
    localparam int idle_w         = $clog2(timeout_cycles + 1);

    localparam logic [cnt_w-1:0]  bit_last  = cnt_w'(bit_period - 1);
    localparam logic [cnt_w-1:0]  half_last = cnt_w'(half_period - 1);
    localparam logic [idle_w-1:0] idle_last = idle_w'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state, state_n;
    logic [cnt_w-1:0]    cnt, cnt_n;
    logic [2:0]          bit_idx, bit_idx_n;
    logic [7:0]          sh, sh_n;
    logic [127:0]        asm_reg, asm_reg_n;
    logic [3:0]          byte_count, byte_count_n;
    logic [idle_w-1:0]   idle_cnt, idle_cnt_n;
    logic [127:0]        digest_n;
    logic                digest_valid_n;
    logic                framing_error_n;
    logic                rx_meta;
    logic                rx_s;

    // Two-flop synchroniser; flops reset to the idle line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            sh            <= '0;
            asm_reg       <= '0;
            byte_count    <= '0;
            idle_cnt      <= '0;
            digest        <= '0;
            digest_valid  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            sh            <= sh_n;
            asm_reg       <= asm_reg_n;
            byte_count    <= byte_count_n;
            idle_cnt      <= idle_cnt_n;
            digest        <= digest_n;
            digest_valid  <= digest_valid_n;
            framing_error <= framing_error_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        bit_idx_n       = bit_idx;
        sh_n            = sh;
        asm_reg_n       = asm_reg;
        byte_count_n    = byte_count;
        idle_cnt_n      = idle_cnt;
        digest_n        = digest;
        digest_valid_n  = 1'b0;
        framing_error_n = 1'b0;

        case (state)
            IDLE: begin
                // Inter-byte timeout only runs while a partial digest is held.
                // It is evaluated before the start check so that a timeout
                // coinciding with a falling edge still begins at byte 0.
                if (byte_count != 4'd0) begin
                    if (idle_cnt == idle_last) begin
                        byte_count_n = 4'd0;
                        idle_cnt_n   = '0;
                    end else begin
                        idle_cnt_n = idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt_n = '0;
                end
                if (!rx_s) begin
                    state_n    = START;
                    cnt_n      = '0;
                    idle_cnt_n = '0;
                end
            end

            START: begin
                if (cnt == half_last) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == bit_last) begin
                    cnt_n     = '0;
                    sh_n      = {rx_s, sh[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == bit_last) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        asm_reg_n = {asm_reg[119:0], sh};
                        state_n   = IDLE;
                        if (byte_count == 4'd15) begin
                            digest_n       = {asm_reg[119:0], sh};
                            digest_valid_n = 1'b1;
                            byte_count_n   = 4'd0;
                        end else begin
                            byte_count_n = byte_count + 4'd1;
                        end
                    end else begin
                        framing_error_n = 1'b1;
                        byte_count_n    = 4'd0;
                        state_n         = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not
                // mistaken for a stream of start bits.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign loading = ((state != IDLE) && (state != WAIT_HIGH)) || (byte_count != 4'd0);

endmodule

// File: tb/tb_uart_digest_loader.sv
// tb/tb_uart_digest_loader.sv - directed self-checking bench for uart_digest_loader
module tb_uart_digest_loader;

    localparam int bit_cycles = 16;

    logic         clock;
    logic         reset;
    logic         rxd;
    logic [127:0] digest;
    logic         digest_valid;
    logic         loading;
    logic         framing_error;

    int checks;
    int failures;
    int valid_pulses;
    int fe_pulses;
    int v0;
    int f0;

    uart_digest_loader #(
        .clock_freq  (16000000),
        .baud        (1000000),
        .timeout_bits(20)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rxd          (rxd),
        .digest       (digest),
        .digest_valid (digest_valid),
        .loading      (loading),
        .framing_error(framing_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts high cycles of each strobe, so a stretched pulse counts twice.
    always @(negedge clock) begin
        if (digest_valid) valid_pulses++;
        if (framing_error) fe_pulses++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (bit_cycles) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        valid_pulses = 0;
        fe_pulses    = 0;
        reset        = 1'b1;
        rxd          = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_digest", digest, 128'h0);
        chk("reset_valid", {127'h0, digest_valid}, 128'h0);
        chk("reset_loading", {127'h0, loading}, 128'h0);
        chk("reset_ferr", {127'h0, framing_error}, 128'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // 16 bytes back-to-back
        v0 = valid_pulses;
        send_seq(8'h00, 16);
        repeat (4) @(negedge clock);
        chk("seq_digest", digest, 128'h000102030405060708090A0B0C0D0E0F);
        chk("seq_pulses", 128'(valid_pulses - v0), 128'd1);
        chk("seq_loading_after", {127'h0, loading}, 128'h0);

        // Short low glitch between bytes must not disturb byte_count
        v0 = valid_pulses;
        f0 = fe_pulses;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rxd = 1'b0;
        repeat (5) @(negedge clock);
        rxd = 1'b1;
        repeat (20) @(negedge clock);
        chk("glitch_no_pulse", 128'(valid_pulses - v0), 128'd0);
        chk("glitch_loading_held", {127'h0, loading}, 128'h1);
        send_seq(8'h30, 14);
        repeat (4) @(negedge clock);
        chk("glitch_digest", digest, 128'h1122303132333435363738393A3B3C3D);
        chk("glitch_pulses", 128'(valid_pulses - v0), 128'd1);
        chk("glitch_ferr", 128'(fe_pulses - f0), 128'd0);

        // Framing error discards partial digest
        v0 = valid_pulses;
        f0 = fe_pulses;
        send_seq(8'h01, 3);
        send_byte(8'h55, 1'b0);
        rxd = 1'b1;
        repeat (8) @(negedge clock);
        chk("ferr_pulse", 128'(fe_pulses - f0), 128'd1);
        chk("ferr_loading", {127'h0, loading}, 128'h0);
        chk("ferr_digest_held", digest, 128'h1122303132333435363738393A3B3C3D);
        for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1);
        repeat (4) @(negedge clock);
        chk("ferr_digest", digest, {128{1'b1}});
        chk("ferr_valid_pulses", 128'(valid_pulses - v0), 128'd1);

        // Idle timeout discards partial digest
        v0 = valid_pulses;
        send_seq(8'h40, 5);
        chk("timeout_loading_before", {127'h0, loading}, 128'h1);
        repeat (25 * bit_cycles) @(negedge clock);
        chk("timeout_loading_after", {127'h0, loading}, 128'h0);
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clock);
        chk("timeout_digest", digest, {16{8'hA5}});
        chk("timeout_pulses", 128'(valid_pulses - v0), 128'd1);

        // Reset during bit 4 of byte 10
        send_seq(8'h60, 9);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_mid_digest", digest, 128'h0);
        chk("rst_mid_loading", {127'h0, loading}, 128'h0);
        chk("rst_mid_valid", {127'h0, digest_valid}, 128'h0);
        chk("rst_mid_ferr", {127'h0, framing_error}, 128'h0);
        @(negedge clock);
        rxd = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        v0 = valid_pulses;
        send_seq(8'h80, 16);
        repeat (4) @(negedge clock);
        chk("rst_reload_digest", digest, 128'h808182838485868788898A8B8C8D8E8F);
        chk("rst_reload_pulses", 128'(valid_pulses - v0), 128'd1);

        // Two digests in succession
        v0 = valid_pulses;
        send_seq(8'hC0, 16);
        send_seq(8'h50, 8);
        chk("two_first_held", digest, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        chk("two_loading_mid", {127'h0, loading}, 128'h1);
        send_seq(8'h58, 8);
        repeat (4) @(negedge clock);
        chk("two_second", digest, 128'h505152535455565758595A5B5C5D5E5F);
        chk("two_pulses", 128'(valid_pulses - v0), 128'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
